// File: rtl/kv_resp_pkg.sv
// Shared types and constants for the KV response builder: status codes, header layout, FSM states.
package kv_resp_pkg;

  localparam int unsigned HDR_BYTES  = 24;
  localparam int unsigned META_W     = 96;
  localparam int unsigned KEY_W      = 64;
  localparam int unsigned VLEN_W     = 16;

  localparam int unsigned META_LSB   = 0;
  localparam int unsigned KEY_LSB    = 96;
  localparam int unsigned VLEN_LSB   = 160;
  localparam int unsigned STATUS_LSB = 176;
  localparam int unsigned MAGIC_LSB  = 184;

  localparam logic [7:0]  RSP_MAGIC  = 8'h81;
  localparam logic [63:0] HDR_KEEP   = (64'd1 << HDR_BYTES) - 64'd1;

  typedef enum logic [7:0] {
    RSP_HIT     = 8'h00,
    RSP_MISS    = 8'h01,
    RSP_TOO_BIG = 8'h02
  } rsp_status_t;

  // Field order mirrors the offsets above, LSB last.
  typedef struct packed {
    logic [319:0]      pad;
    logic [7:0]        magic;
    rsp_status_t       status;
    logic [VLEN_W-1:0] vlen;
    logic [KEY_W-1:0]  key;
    logic [META_W-1:0] meta;
  } rsp_hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    VAL,
    DRAIN
  } fsm_state_t;

  function automatic logic [63:0] tail_keep(input logic [5:0] rem);
    if (rem == 6'd0) return '1;
    return (64'd1 << rem) - 64'd1;
  endfunction

endpackage

// File: rtl/kv_response_builder_axis_pipe_reg.sv
// Single-stage AXIS output register (data, keep, last) shared by TX-path blocks.
module axis_pipe_reg #(
  parameter int unsigned DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_tkeep,
  input  logic                    s_tlast,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic [DATA_WIDTH/8-1:0] m_tkeep,
  output logic                    m_tlast,
  output logic                    m_tvalid,
  input  logic                    m_tready
);

  assign s_tready = !m_tvalid || m_tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tvalid <= 1'b0;
    end else if (s_tvalid && s_tready) begin
      m_tdata  <= s_tdata;
      m_tkeep  <= s_tkeep;
      m_tlast  <= s_tlast;
      m_tvalid <= 1'b1;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/kv_response_builder.sv
// Builds one response packet (header beat + value beats) per joined metadata/lookup pair.
module kv_response_builder
  import kv_resp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned META_WIDTH      = 96,
  parameter int unsigned MAX_VALUE_BYTES = 4096
) (
  input  logic                    axis_clk,
  input  logic                    axis_rst,
  input  logic [META_WIDTH-1:0]   s_meta_data,
  input  logic                    s_meta_valid,
  output logic                    s_meta_ready,
  input  logic                    s_rsp_hit,
  input  logic [63:0]             s_rsp_key,
  input  logic [15:0]             s_rsp_vlen,
  input  logic                    s_rsp_valid,
  output logic                    s_rsp_ready,
  input  logic [DATA_WIDTH-1:0]   s_value_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_value_tkeep,
  input  logic                    s_value_tlast,
  input  logic                    s_value_tvalid,
  output logic                    s_value_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [31:0]             stat_rsp_cnt,
  output logic [31:0]             stat_hit_cnt,
  output logic [31:0]             stat_err_cnt
);

  fsm_state_t               state_q, state_d;
  logic [META_WIDTH-1:0]    meta_q;
  logic [63:0]              key_q;
  logic [15:0]              vlen_q;
  rsp_status_t              status_q, status_d;
  logic [6:0]               beat_q, last_beat_q;
  logic [15:0]              vlen_m1;
  logic                     join_ok, out_ready, is_last_beat;
  logic                     pipe_valid, pipe_last, pipe_is_hdr, beat_take, err_inc;
  logic [DATA_WIDTH-1:0]    pipe_data;
  logic [DATA_WIDTH/8-1:0]  pipe_keep;
  logic                     out_is_hdr_q, out_is_hit_q;
  rsp_hdr_t                 hdr;

  assign join_ok      = (state_q == IDLE) && s_meta_valid && s_rsp_valid && !axis_rst;
  assign vlen_m1      = s_rsp_vlen - 16'd1;
  assign is_last_beat = (beat_q == last_beat_q);

  always_comb begin
    status_d = RSP_HIT;
    if (!s_rsp_hit)                              status_d = RSP_MISS;
    else if (32'(s_rsp_vlen) > MAX_VALUE_BYTES)  status_d = RSP_TOO_BIG;
  end

  always_comb begin
    hdr        = '0;
    hdr.meta   = meta_q;
    hdr.key    = key_q;
    hdr.vlen   = vlen_q;
    hdr.status = status_q;
    hdr.magic  = RSP_MAGIC;
  end

  always_comb begin
    state_d        = state_q;
    s_meta_ready   = 1'b0;
    s_rsp_ready    = 1'b0;
    s_value_tready = 1'b0;
    pipe_valid     = 1'b0;
    pipe_data      = hdr;
    pipe_keep      = HDR_KEEP;
    pipe_last      = 1'b1;
    pipe_is_hdr    = 1'b0;
    beat_take      = 1'b0;
    err_inc        = 1'b0;
    case (state_q)
      IDLE: begin
        s_meta_ready = join_ok;
        s_rsp_ready  = join_ok;
        if (join_ok) state_d = HDR;
      end
      HDR: begin
        pipe_valid  = 1'b1;
        pipe_is_hdr = 1'b1;
        pipe_last   = !(status_q == RSP_HIT && vlen_q != 16'd0);
        if (out_ready) begin
          if (status_q == RSP_HIT && vlen_q != 16'd0) state_d = VAL;
          else if (status_q == RSP_TOO_BIG)          state_d = DRAIN;
          else                                       state_d = IDLE;
        end
      end
      VAL: begin
        s_value_tready = out_ready;
        pipe_valid     = s_value_tvalid;
        pipe_data      = s_value_tdata;
        pipe_keep      = '1;
        pipe_last      = 1'b0;
        // The expected length wins over the source's tlast on the final beat.
        if (is_last_beat) begin
          pipe_last = 1'b1;
          pipe_keep = tail_keep(vlen_q[5:0]);
        end else if (s_value_tlast) begin
          pipe_last = 1'b1;
          pipe_keep = s_value_tkeep;
        end
        if (s_value_tvalid && out_ready) begin
          beat_take = 1'b1;
          if (is_last_beat) begin
            state_d = s_value_tlast ? IDLE : DRAIN;
            err_inc = !s_value_tlast;
          end else if (s_value_tlast) begin
            state_d = IDLE;
            err_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        s_value_tready = 1'b1;
        if (s_value_tvalid && s_value_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (axis_rst) begin
      s_value_tready = 1'b0;
      pipe_valid     = 1'b0;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q      <= IDLE;
      meta_q       <= '0;
      key_q        <= '0;
      vlen_q       <= '0;
      status_q     <= RSP_HIT;
      beat_q       <= '0;
      last_beat_q  <= '0;
      out_is_hdr_q <= 1'b0;
      out_is_hit_q <= 1'b0;
      stat_rsp_cnt <= '0;
      stat_hit_cnt <= '0;
      stat_err_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (join_ok) begin
        meta_q      <= s_meta_data;
        key_q       <= s_rsp_key;
        vlen_q      <= (status_d == RSP_HIT) ? s_rsp_vlen : 16'd0;
        status_q    <= status_d;
        beat_q      <= '0;
        last_beat_q <= 7'(vlen_m1 >> 6);
      end else if (beat_take) begin
        beat_q <= beat_q + 7'd1;
      end
      if (pipe_valid && out_ready) begin
        out_is_hdr_q <= pipe_is_hdr;
        out_is_hit_q <= pipe_is_hdr && (status_q == RSP_HIT);
      end
      if (m_axis_tvalid && m_axis_tready && out_is_hdr_q) begin
        stat_rsp_cnt <= stat_rsp_cnt + 32'd1;
        if (out_is_hit_q) stat_hit_cnt <= stat_hit_cnt + 32'd1;
      end
      if (err_inc) stat_err_cnt <= stat_err_cnt + 32'd1;
    end
  end

  axis_pipe_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (axis_clk),
    .rst      (axis_rst),
    .s_tdata  (pipe_data),
    .s_tkeep  (pipe_keep),
    .s_tlast  (pipe_last),
    .s_tvalid (pipe_valid),
    .s_tready (out_ready),
    .m_tdata  (m_axis_tdata),
    .m_tkeep  (m_axis_tkeep),
    .m_tlast  (m_axis_tlast),
    .m_tvalid (m_axis_tvalid),
    .m_tready (m_axis_tready)
  );

endmodule

// File: tb/tb_kv_response_builder.sv
// Directed plus randomized bench for kv_response_builder with a packet-level reference model.
`timescale 1ns/1ps
module tb_kv_response_builder;

  logic         axis_clk, axis_rst;
  logic [95:0]  s_meta_data;
  logic         s_meta_valid, s_meta_ready;
  logic         s_rsp_hit;
  logic [63:0]  s_rsp_key;
  logic [15:0]  s_rsp_vlen;
  logic         s_rsp_valid, s_rsp_ready;
  logic [511:0] s_value_tdata;
  logic [63:0]  s_value_tkeep;
  logic         s_value_tlast, s_value_tvalid, s_value_tready;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic         m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [31:0]  stat_rsp_cnt, stat_hit_cnt, stat_err_cnt;

  kv_response_builder #(
    .DATA_WIDTH(512),
    .META_WIDTH(96),
    .MAX_VALUE_BYTES(4096)
  ) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .s_meta_data(s_meta_data), .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready),
    .s_rsp_hit(s_rsp_hit), .s_rsp_key(s_rsp_key), .s_rsp_vlen(s_rsp_vlen),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
    .s_value_tdata(s_value_tdata), .s_value_tkeep(s_value_tkeep), .s_value_tlast(s_value_tlast),
    .s_value_tvalid(s_value_tvalid), .s_value_tready(s_value_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .stat_rsp_cnt(stat_rsp_cnt), .stat_hit_cnt(stat_hit_cnt), .stat_err_cnt(stat_err_cnt)
  );

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        act_q[$];
  beat_t        mon_b;
  int           checks   = 0;
  int           failures = 0;
  int unsigned  m_rsp = 0, m_hit = 0, m_err = 0;
  bit           bp_en = 1'b0;
  logic         prev_stall;
  logic [511:0] prev_data;
  logic [63:0]  prev_keep;
  logic         prev_last;

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge axis_clk);
      #1;
      m_axis_tready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Output monitor: records transfers and checks the held beat while stalled.
  always @(negedge axis_clk) begin
    if (axis_rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        assert ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} === {prev_data, prev_keep, prev_last})
        else begin
          failures++;
          $error("FAIL stall_hold observed keep=%h last=%b required keep=%h last=%b",
                 m_axis_tkeep, m_axis_tlast, prev_keep, prev_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        mon_b.data = m_axis_tdata;
        mon_b.keep = m_axis_tkeep;
        mon_b.last = m_axis_tlast;
        act_q.push_back(mon_b);
      end
      prev_stall <= m_axis_tvalid && !m_axis_tready;
      prev_data  <= m_axis_tdata;
      prev_keep  <= m_axis_tkeep;
      prev_last  <= m_axis_tlast;
    end
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int unsigned i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [63:0] byte_mask(input int unsigned nbytes);
    logic [63:0] m = '0;
    for (int unsigned b = 0; b < 64; b++) if (b < nbytes) m[b] = 1'b1;
    return m;
  endfunction

  task automatic send_join(input logic [95:0] meta, input logic [63:0] key,
                           input logic hit, input logic [15:0] vlen);
    bit ok = 1'b0;
    s_meta_data = meta; s_rsp_key = key; s_rsp_hit = hit; s_rsp_vlen = vlen;
    s_meta_valid = 1'b1; s_rsp_valid = 1'b1;
    for (int unsigned c = 0; c < 200 && !ok; c++) begin
      @(negedge axis_clk);
      ok = s_meta_ready && s_rsp_ready;
    end
    chk("join_timeout", 512'(ok), 512'd1);
    @(posedge axis_clk);
    #1;
    s_meta_valid = 1'b0; s_rsp_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic l);
    bit ok = 1'b0;
    s_value_tdata = d; s_value_tkeep = k; s_value_tlast = l; s_value_tvalid = 1'b1;
    for (int unsigned c = 0; c < 500 && !ok; c++) begin
      @(negedge axis_clk);
      ok = s_value_tready;
    end
    chk("value_timeout", 512'(ok), 512'd1);
    @(posedge axis_clk);
    #1;
    s_value_tvalid = 1'b0;
  endtask

  // Reference model: expected packet from the lookup result and the source beat count.
  task automatic do_req(input logic [95:0] meta, input logic [63:0] key, input logic hit,
                        input logic [15:0] vlen, input int unsigned nsrc);
    logic [7:0]   status;
    logic [15:0]  vl;
    beat_t        b;
    beat_t        src[$];
    int unsigned  exp_n;
    bit           ok;
    if (failures > 20) return;
    status = !hit ? 8'h01 : (vlen > 16'd4096) ? 8'h02 : 8'h00;
    vl     = (status == 8'h00) ? vlen : 16'd0;
    exp_n  = (status == 8'h00) ? (int'(vl) + 63) / 64 : 0;
    b.data = '0;
    b.data[95:0]    = meta;
    b.data[159:96]  = key;
    b.data[175:160] = vl;
    b.data[183:176] = status;
    b.data[191:184] = 8'h81;
    b.keep = byte_mask(24);
    b.last = (exp_n == 0);
    exp_q.push_back(b);
    m_rsp++;
    if (status == 8'h00) m_hit++;
    for (int unsigned i = 0; i < nsrc; i++) begin
      b.data = rnd512();
      b.keep = 64'($urandom) << 32 | 64'($urandom);
      b.last = (i == nsrc - 1);
      src.push_back(b);
    end
    if (exp_n != 0) begin
      for (int unsigned i = 0; i < nsrc && i < exp_n; i++) begin
        b.data = src[i].data;
        if (i == exp_n - 1) begin
          b.keep = byte_mask(int'(vl) - 64 * i);
          b.last = 1'b1;
        end else if (i == nsrc - 1) begin
          b.keep = src[i].keep;
          b.last = 1'b1;
        end else begin
          b.keep = '1;
          b.last = 1'b0;
        end
        exp_q.push_back(b);
      end
      if (nsrc != exp_n) m_err++;
    end
    send_join(meta, key, hit, vlen);
    foreach (src[i]) send_beat(src[i].data, src[i].keep, src[i].last);
    ok = 1'b0;
    for (int unsigned c = 0; c < 2000 && !ok; c++) begin
      @(negedge axis_clk);
      ok = (act_q.size() >= exp_q.size());
    end
    chk("output_timeout", 512'(ok), 512'd1);
    while (exp_q.size() != 0 && act_q.size() != 0) begin
      beat_t e, a;
      e = exp_q.pop_front();
      a = act_q.pop_front();
      chk("tdata", a.data, e.data);
      chk("tkeep", 512'(a.keep), 512'(e.keep));
      chk("tlast", 512'(a.last), 512'(e.last));
    end
    exp_q.delete();
    @(posedge axis_clk);
    @(negedge axis_clk);
    chk("stat_rsp_cnt", 512'(stat_rsp_cnt), 512'(m_rsp));
    chk("stat_hit_cnt", 512'(stat_hit_cnt), 512'(m_hit));
    chk("stat_err_cnt", 512'(stat_err_cnt), 512'(m_err));
    @(posedge axis_clk);
    #1;
  endtask

  initial begin
    logic        hit;
    logic [15:0] vlen;
    int unsigned nsrc, exp_n, r;

    axis_rst = 1'b1;
    s_meta_data = '0; s_rsp_key = '0; s_rsp_hit = 1'b0; s_rsp_vlen = '0;
    s_meta_valid = 1'b1; s_rsp_valid = 1'b1;
    s_value_tdata = '0; s_value_tkeep = '0; s_value_tlast = 1'b0; s_value_tvalid = 1'b1;
    repeat (3) @(posedge axis_clk);
    @(negedge axis_clk);
    chk("rst_tvalid", 512'(m_axis_tvalid), 512'd0);
    chk("rst_tdata", m_axis_tdata, 512'd0);
    chk("rst_tkeep", 512'(m_axis_tkeep), 512'd0);
    chk("rst_tlast", 512'(m_axis_tlast), 512'd0);
    chk("rst_readies", 512'({s_meta_ready, s_rsp_ready, s_value_tready}), 512'd0);
    chk("rst_counters", 512'({stat_rsp_cnt, stat_hit_cnt, stat_err_cnt}), 512'd0);
    @(posedge axis_clk);
    #1;
    s_meta_valid = 1'b0; s_rsp_valid = 1'b0; s_value_tvalid = 1'b0;
    axis_rst = 1'b0;
    @(posedge axis_clk);
    #1;

    do_req(96'h1, 64'hDEAD_BEEF, 1'b0, 16'd0, 0);
    do_req(96'h2222, 64'h1111, 1'b1, 16'd100, 2);
    do_req(96'h3333, 64'h2222, 1'b1, 16'd128, 1);
    do_req(96'h4444, 64'h3333, 1'b0, 16'd77, 0);
    do_req(96'h5555, 64'h4444, 1'b1, 16'd64, 3);
    do_req(96'h6666, 64'h5555, 1'b1, 16'd5000, 3);
    do_req(96'h7777, 64'h6666, 1'b1, 16'd0, 0);
    do_req(96'h8888, 64'h7777, 1'b1, 16'd4096, 64);

    bp_en = 1'b1;
    for (int unsigned n = 0; n < 1000; n++) begin
      hit = ($urandom_range(0, 9) != 0);
      r   = $urandom_range(0, 19);
      if (r == 0)      vlen = 16'($urandom_range(4097, 65535));
      else if (r == 1) vlen = 16'd0;
      else if (r == 2) vlen = 16'd4096;
      else             vlen = 16'($urandom_range(1, 600));
      nsrc = 0;
      if (hit && vlen > 16'd4096) begin
        nsrc = $urandom_range(1, 3);
      end else if (hit && vlen != 16'd0) begin
        exp_n = (int'(vlen) + 63) / 64;
        r     = $urandom_range(0, 9);
        if (r == 0 && exp_n > 1) nsrc = $urandom_range(1, exp_n - 1);
        else if (r == 1)         nsrc = exp_n + $urandom_range(1, 2);
        else                     nsrc = exp_n;
      end
      do_req({$urandom, $urandom, $urandom}, {$urandom, $urandom}, hit, vlen, nsrc);
    end

    // Reset in the middle of a value stream.
    bp_en = 1'b0;
    @(posedge axis_clk);
    #1;
    send_join(96'h9999, 64'hABCD, 1'b1, 16'd640);
    for (int unsigned i = 0; i < 3; i++) send_beat(rnd512(), '1, 1'b0);
    s_value_tvalid = 1'b1;
    axis_rst = 1'b1;
    @(posedge axis_clk);
    #1;
    axis_rst = 1'b0;
    @(negedge axis_clk);
    chk("midval_rst_tready", 512'(s_value_tready), 512'd0);
    chk("midval_rst_tvalid", 512'(m_axis_tvalid), 512'd0);
    chk("midval_rst_counters", 512'({stat_rsp_cnt, stat_hit_cnt, stat_err_cnt}), 512'd0);
    @(posedge axis_clk);
    #1;
    s_value_tvalid = 1'b0;
    act_q.delete();
    exp_q.delete();
    m_rsp = 0; m_hit = 0; m_err = 0;
    do_req(96'hAAAA, 64'hBBBB, 1'b0, 16'd0, 0);

    repeat (5) @(posedge axis_clk);
    @(negedge axis_clk);
    chk("no_extra_beats", 512'(act_q.size()), 512'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
